// File: rtl/topk_neighbor_select.sv
// topk_neighbor_select
// Reads one node's neighbour table out of the shared data memory and keeps up to K
// neighbours. In MATCH mode it keeps the first K exact matches to the (Q, hops) key.
// In RANK mode it keeps the top K by Q, higher first, with fewer hops breaking Q ties.
// Results stay on the outputs until the next accepted start.
module topk_neighbor_select #(
  parameter int WORD_W  = 16,
  parameter int ADDR_W  = 11,
  parameter int MAX_NBR = 32,
  parameter int K       = 4,
  parameter int CNT_W   = 6
) (
  input  logic                clock,
  input  logic                nrst,
  input  logic                en,
  input  logic                start,
  input  logic                mode,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [WORD_W-1:0]   mybestQ,
  input  logic [WORD_W-1:0]   mybestH,
  input  logic [WORD_W-1:0]   data_in,
  output logic                mem_rd,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    found,
  output logic [K*WORD_W-1:0] best_id,
  output logic [K*WORD_W-1:0] best_hop,
  output logic [K*WORD_W-1:0] best_q
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LCNT, S_LID, S_LHOP, S_LQ, S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  // Scan parameters, latched when a start is accepted
  logic              r_mode;
  logic [WORD_W-1:0] r_keyq;
  logic [WORD_W-1:0] r_keyh;

  // Read pointer. It always holds the address of the next word to fetch.
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_remain;

  // Neighbour currently being assembled. Its Q is taken straight from data_in in LQ.
  logic [WORD_W-1:0] r_cur_id;
  logic [WORD_W-1:0] r_cur_hop;

  // Result slots. Slot 0 is the best.
  logic [WORD_W-1:0] r_id  [K];
  logic [WORD_W-1:0] r_hop [K];
  logic [WORD_W-1:0] r_q   [K];
  logic [CNT_W-1:0]  r_found;

  // Slot contents that the candidate evaluated in LQ would produce
  logic [WORD_W-1:0] w_id_nx  [K];
  logic [WORD_W-1:0] w_hop_nx [K];
  logic [WORD_W-1:0] w_q_nx   [K];
  logic [CNT_W-1:0]  w_found_nx;
  int                w_pos;

  logic [CNT_W-1:0]  w_n;
  logic              w_last;

  // A stored count above MAX_NBR is clamped. Only the first MAX_NBR entries are scanned.
  assign w_n    = (data_in > WORD_W'(MAX_NBR)) ? CNT_W'(MAX_NBR) : data_in[CNT_W-1:0];
  assign w_last = (r_remain == CNT_W'(1));

  assign mem_addr = r_addr;
  assign found    = r_found;

  genvar g;
  generate
    for (g = 0; g < K; g++) begin : g_pack
      assign best_id [g*WORD_W +: WORD_W] = r_id[g];
      assign best_hop[g*WORD_W +: WORD_W] = r_hop[g];
      assign best_q  [g*WORD_W +: WORD_W] = r_q[g];
    end
  endgenerate

  // State register. Reset aborts any scan in progress.
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state and strobes. When en is low the FSM holds and no read is issued.
  always_comb begin
    w_next = r_state;
    mem_rd = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next = S_FETCH;
      S_FETCH: begin
        busy   = 1'b1;
        mem_rd = 1'b1;
        w_next = S_LCNT;
      end
      S_LCNT: begin
        busy = 1'b1;
        if (w_n == '0) begin
          w_next = S_DONE;
        end else begin
          mem_rd = 1'b1;
          w_next = S_LID;
        end
      end
      S_LID: begin
        busy   = 1'b1;
        mem_rd = 1'b1;
        w_next = S_LHOP;
      end
      S_LHOP: begin
        busy   = 1'b1;
        mem_rd = 1'b1;
        w_next = S_LQ;
      end
      S_LQ: begin
        busy = 1'b1;
        if (w_last) begin
          w_next = S_DONE;
        end else begin
          mem_rd = 1'b1;
          w_next = S_LID;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (!en) begin
      w_next = r_state;
      mem_rd = 1'b0;
      done   = 1'b0;
    end
  end

  // Evaluate the candidate (r_cur_id, r_cur_hop, data_in) against the current slots
  always_comb begin
    for (int i = 0; i < K; i++) begin
      w_id_nx[i]  = r_id[i];
      w_hop_nx[i] = r_hop[i];
      w_q_nx[i]   = r_q[i];
    end
    w_found_nx = r_found;
    w_pos      = K;
    if (!r_mode) begin
      // MATCH: append in table order until every slot is filled
      if (data_in == r_keyq && r_cur_hop == r_keyh && r_found < CNT_W'(K)) begin
        for (int i = 0; i < K; i++) begin
          if (CNT_W'(i) == r_found) begin
            w_id_nx[i]  = r_cur_id;
            w_hop_nx[i] = r_cur_hop;
            w_q_nx[i]   = data_in;
          end
        end
        w_found_nx = r_found + CNT_W'(1);
      end
    end else begin
      // RANK: the candidate goes into the first slot it strictly beats.
      // An empty slot counts as beaten. A full tie loses, so earlier entries stay ahead.
      for (int i = K - 1; i >= 0; i--) begin
        if (CNT_W'(i) >= r_found || data_in > r_q[i] ||
            (data_in == r_q[i] && r_cur_hop < r_hop[i]))
          w_pos = i;
      end
      for (int i = 1; i < K; i++) begin
        if (i > w_pos) begin
          w_id_nx[i]  = r_id[i-1];
          w_hop_nx[i] = r_hop[i-1];
          w_q_nx[i]   = r_q[i-1];
        end
      end
      for (int i = 0; i < K; i++) begin
        if (i == w_pos) begin
          w_id_nx[i]  = r_cur_id;
          w_hop_nx[i] = r_cur_hop;
          w_q_nx[i]   = data_in;
        end
      end
      if (w_pos < K && r_found < CNT_W'(K)) w_found_nx = r_found + CNT_W'(1);
    end
  end

  // Datapath: latch on start, advance the read pointer, capture fields, update the slots
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      r_mode    <= 1'b0;
      r_keyq    <= '0;
      r_keyh    <= '0;
      r_addr    <= '0;
      r_remain  <= '0;
      r_cur_id  <= '0;
      r_cur_hop <= '0;
      r_found   <= '0;
      for (int i = 0; i < K; i++) begin
        r_id[i]  <= '0;
        r_hop[i] <= '0;
        r_q[i]   <= '0;
      end
    end else if (en) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode  <= mode;
            r_keyq  <= mybestQ;
            r_keyh  <= mybestH;
            r_addr  <= base_addr;
            r_found <= '0;
            for (int i = 0; i < K; i++) begin
              r_id[i]  <= '0;
              r_hop[i] <= '0;
              r_q[i]   <= '0;
            end
          end
        end
        S_FETCH: r_addr <= r_addr + ADDR_W'(1);
        S_LCNT: begin
          r_remain <= w_n;
          if (w_n != '0) r_addr <= r_addr + ADDR_W'(1);
        end
        S_LID: begin
          r_cur_id <= data_in;
          r_addr   <= r_addr + ADDR_W'(1);
        end
        S_LHOP: begin
          r_cur_hop <= data_in;
          r_addr    <= r_addr + ADDR_W'(1);
        end
        S_LQ: begin
          r_remain <= r_remain - CNT_W'(1);
          if (!w_last) r_addr <= r_addr + ADDR_W'(1);
          r_found <= w_found_nx;
          for (int i = 0; i < K; i++) begin
            r_id[i]  <= w_id_nx[i];
            r_hop[i] <= w_hop_nx[i];
            r_q[i]   <= w_q_nx[i];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
